// File: rtl/hash_tx_sequencer.sv
// Streams a latched 256-bit digest as 64 hex characters through an ASCII converter to a UART.
// Define HASH_TX_CRLF_EN to append CR and LF, for 66 characters per transmission.
module hash_tx_sequencer (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         start_i,
  input  logic [255:0] digest_i,
  input  logic         ascii_available_i,
  input  logic         tx_busy_i,
  output logic [3:0]   hex_out_o,
  output logic         conv_en_o,
  output logic         send_cr_o,
  output logic         send_lf_o,
  output logic         tx_start_o,
  output logic         busy_o,
  output logic         done_o
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] CONV      = 3'd1;
  localparam logic [2:0] WAIT_CONV = 3'd2;
  localparam logic [2:0] TX_REQ    = 3'd3;
  localparam logic [2:0] TX_GAP    = 3'd4;
  localparam logic [2:0] TX_WAIT   = 3'd5;
  localparam logic [2:0] FINISH    = 3'd6;

`ifdef HASH_TX_CRLF_EN
  localparam logic [6:0] LAST_IDX = 7'd65;
`else
  localparam logic [6:0] LAST_IDX = 7'd63;
`endif

  logic [2:0]   state_q, state_d;
  logic [6:0]   idx_q, idx_d;
  logic [255:0] shadow_q, shadow_d;
  logic [3:0]   hex_q, hex_d;
  logic         conv_q, conv_d;
  logic         cr_q, cr_d;
  logic         lf_q, lf_d;
  logic         txs_q, txs_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          shadow_d = digest_i;
          idx_d    = 7'd0;
          state_d  = CONV;
        end
      end
      CONV:      state_d = WAIT_CONV;
      WAIT_CONV: if (ascii_available_i) state_d = TX_REQ;
      TX_REQ:    if (!tx_busy_i) state_d = TX_GAP;
      TX_GAP:    state_d = TX_WAIT;
      TX_WAIT: begin
        if (!tx_busy_i) begin
          if (idx_q == LAST_IDX) begin
            state_d = FINISH;
          end else begin
            idx_d   = idx_q + 7'd1;
            state_d = CONV;
          end
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so each register lines up with the state it belongs to.
  always_comb begin
    conv_d = (state_d == CONV);
    hex_d  = 4'd0;
    if (conv_d && (idx_d < 7'd64)) begin
      hex_d = shadow_d[{~idx_d[5:0], 2'b00} +: 4];
    end
`ifdef HASH_TX_CRLF_EN
    cr_d = conv_d && (idx_d == 7'd64);
    lf_d = conv_d && (idx_d == 7'd65);
`else
    cr_d = 1'b0;
    lf_d = 1'b0;
`endif
    txs_d  = (state_q == TX_REQ) && !tx_busy_i;
    busy_d = (state_d != IDLE);
    done_d = (state_d == FINISH);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q  <= IDLE;
      idx_q    <= 7'd0;
      shadow_q <= '0;
      hex_q    <= 4'd0;
      conv_q   <= 1'b0;
      cr_q     <= 1'b0;
      lf_q     <= 1'b0;
      txs_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      hex_q    <= hex_d;
      conv_q   <= conv_d;
      cr_q     <= cr_d;
      lf_q     <= lf_d;
      txs_q    <= txs_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign hex_out_o  = hex_q;
  assign conv_en_o  = conv_q;
  assign send_cr_o  = cr_q;
  assign send_lf_o  = lf_q;
  assign tx_start_o = txs_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;

endmodule
